// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arbiter_pkg : shared types, requester indices and parameter defaults
// Revision: 1.0
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQUEST   = 3'd1,
    WAIT_IDLE = 3'd2,
    OWN       = 3'd3,
    RELEASE   = 3'd4
  } arb_state_e;

  localparam int MON = 0;
  localparam int DMA = 1;

  localparam int BG_TIMEOUT_DEF = 1024;
  localparam int HOLD_MAX_DEF   = 256;
  localparam int CPU_GAP_DEF    = 4;

  function automatic logic [1:0] onehot2(input logic idx);
    return (idx == 1'(DMA)) ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_select : combinational 2-way round-robin pick (tie goes to non-last owner)
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_select
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'(MON);
    if (req == 2'b10) begin
      winner = 1'(DMA);
    end else if (req == 2'b11) begin
      winner = ~last_owner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arbiter : 68k-style BR/BG/BGACK handshake arbitrating two bus masters
// Revision: 1.0
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int BG_TIMEOUT = BG_TIMEOUT_DEF,
  parameter int HOLD_MAX   = HOLD_MAX_DEF,
  parameter int CPU_GAP    = CPU_GAP_DEF
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET_n_IN,
  input  logic [1:0] REQ_IN,
  input  logic       BG_IN,
  input  logic       AS_IN,
  output logic       BR,
  output logic       BGACK,
  output logic [1:0] GNT,
  output logic       TIMEOUT,
  output logic       PREEMPT
);

  localparam int WAIT_W = $clog2(BG_TIMEOUT) + 1;
  localparam int HOLD_W = $clog2(HOLD_MAX) + 1;
  localparam int GAP_W  = $clog2(CPU_GAP) + 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BG_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(CPU_GAP);

  arb_state_e        state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_owner_q, last_owner_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              br_q, br_d;
  logic              bgack_q, bgack_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              timeout_q, timeout_d;
  logic              preempt_q, preempt_d;

  logic              pick_valid;
  logic              pick_winner;

  rr_select u_rr_select (
    .req        (REQ_IN),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_owner_d = last_owner_q;
    wait_d       = wait_q;
    hold_d       = hold_q;
    gap_d        = gap_q;
    br_d         = br_q;
    bgack_d      = bgack_q;
    gnt_d        = gnt_q;
    timeout_d    = 1'b0;
    preempt_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        br_d    = 1'b0;
        bgack_d = 1'b0;
        gnt_d   = 2'b00;
        // Requests seen during the CPU gap simply wait here until it expires.
        if (gap_q < GAP_FULL) begin
          gap_d = gap_q + 1'b1;
        end else if (pick_valid) begin
          winner_d = pick_winner;
          wait_d   = '0;
          br_d     = 1'b1;
          state_d  = REQUEST;
        end
      end

      REQUEST: begin
        if (!REQ_IN[winner_q]) begin
          br_d    = 1'b0;
          state_d = IDLE;
        end else if (BG_IN) begin
          state_d = WAIT_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          br_d      = 1'b0;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (!BG_IN) begin
          wait_d  = '0;
          state_d = REQUEST;
        end else if (!AS_IN) begin
          br_d    = 1'b0;
          bgack_d = 1'b1;
          gnt_d   = onehot2(winner_q);
          hold_d  = '0;
          state_d = OWN;
        end
      end

      OWN: begin
        // A voluntary release beats the forced one in the same cycle.
        if (!REQ_IN[winner_q]) begin
          gnt_d   = 2'b00;
          state_d = RELEASE;
        end else if (hold_q == HOLD_LAST) begin
          gnt_d     = 2'b00;
          preempt_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      RELEASE: begin
        bgack_d      = 1'b0;
        last_owner_d = winner_q;
        gap_d        = '0;
        state_d      = IDLE;
      end

      default: begin
        br_d    = 1'b0;
        bgack_d = 1'b0;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CPUCLK_IN or negedge RESET_n_IN) begin
    if (!RESET_n_IN) begin
      state_q      <= IDLE;
      winner_q     <= 1'(MON);
      last_owner_q <= 1'(DMA);
      wait_q       <= '0;
      hold_q       <= '0;
      gap_q        <= GAP_FULL;
      br_q         <= 1'b0;
      bgack_q      <= 1'b0;
      gnt_q        <= 2'b00;
      timeout_q    <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_owner_q <= last_owner_d;
      wait_q       <= wait_d;
      hold_q       <= hold_d;
      gap_q        <= gap_d;
      br_q         <= br_d;
      bgack_q      <= bgack_d;
      gnt_q        <= gnt_d;
      timeout_q    <= timeout_d;
      preempt_q    <= preempt_d;
    end
  end

  assign BR      = br_q;
  assign BGACK   = bgack_q;
  assign GNT     = gnt_q;
  assign TIMEOUT = timeout_q;
  assign PREEMPT = preempt_q;

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BG_TIMEOUT, default 1024; max cycles BR is held awaiting BG before abandoning the request.
REQ-002 Parameter HOLD_MAX, default 256; max cycles one requester may own the bus before forced release.
REQ-003 Parameter CPU_GAP, default 4; minimum idle cycles returned to the CPU between consecutive external ownerships.
REQ-004 CPUCLK_IN  in  1  sole clock; all logic rising-edge.
REQ-005 RESET_n_IN  in  1  reset, asynchronous assert, active-low.
REQ-006 REQ_IN  in  2  bus requests, active-high; bit0 = SPI monitor master, bit1 = DMA master.
REQ-007 BG_IN  in  1  CPU bus grant, active-high, already inverted and synchronised upstream.
REQ-008 AS_IN  in  1  CPU address strobe, active-high.
REQ-009 BR  out  1  bus request to CPU, active-high; top level inverts to BR_n.
REQ-010 BGACK  out  1  bus grant acknowledge, active-high; top level inverts to BGACK_n.
REQ-011 GNT  out  2  one-hot grant to requesters; never more than one bit set.
REQ-012 TIMEOUT  out  1  one-cycle pulse when a BG wait is abandoned.
REQ-013 PREEMPT  out  1  one-cycle pulse when an owner is forcibly released at HOLD_MAX.

Function
REQ-014 FSM states SHALL be IDLE, REQUEST, WAIT_IDLE, OWN and RELEASE; all outputs SHALL be registered.
REQ-015 IDLE: BR=0, BGACK=0, GNT=0; once the gap counter >= CPU_GAP and any REQ_IN bit is set, latch the winner and go to REQUEST.
REQ-016 Winner selection: a single request wins; with both set, the requester that was NOT the last owner wins (round-robin).
REQ-017 REQUEST: BR=1; wait counter increments each cycle; on BG_IN=1 go to WAIT_IDLE.
REQ-018 REQUEST with wait counter = BG_TIMEOUT-1 and no BG_IN: pulse TIMEOUT, BR=0, go to IDLE; last owner unchanged.
REQ-019 REQUEST with the winner's REQ_IN dropped before BG_IN: BR=0, go to IDLE, no pulse.
REQ-020 WAIT_IDLE: BR=1; on a cycle with AS_IN=0 and BG_IN=1, go to OWN; BGACK=1, BR=0 and GNT[winner]=1 SHALL all take effect on the same edge.
REQ-021 WAIT_IDLE with BG_IN=0: return to REQUEST with the wait counter reset to 0.
REQ-022 OWN: BGACK=1, GNT[winner]=1; hold counter increments from 0 at entry.
REQ-023 OWN, REQ_IN[winner]=0: go to RELEASE.
REQ-024 OWN, hold counter = HOLD_MAX-1: go to RELEASE and pulse PREEMPT; the REQ_IN drop takes precedence if it occurs in the same cycle (no pulse).
REQ-025 RELEASE lasts exactly one cycle: GNT=0, BGACK=1 (bus turnaround); then IDLE with BGACK=0, last owner := winner, gap counter := 0.
REQ-026 Gap counter saturates at CPU_GAP; requests arriving during the gap are held pending, not dropped.
REQ-027 A requester still asserting REQ_IN after forced release re-arbitrates normally; round-robin favours the other requester.
REQ-028 Counters are sized $clog2 of their parameter +1 and SHALL saturate, never wrap.

Reset
REQ-029 RESET_n_IN low SHALL immediately force: state IDLE; BR, BGACK, GNT, TIMEOUT and PREEMPT all 0; counters 0; gap counter = CPU_GAP; last owner = 1 (requester 0 wins the first tie).
REQ-030 Reset asserted during OWN SHALL drop BGACK and GNT asynchronously; no RELEASE cycle is issued.

Structure
REQ-031 Package bus_arbiter_pkg SHALL hold the state enum, requester index constants (MON=0, DMA=1) and the parameter defaults.
REQ-032 One sub-module, rr_select: combinational 2-way round-robin pick from REQ_IN and last owner.

Verification
REQ-033 After reset, REQ_IN=01, BG_IN asserted 3 cycles after BR, AS_IN=0 -> BGACK=1 and GNT=01 one cycle after BG_IN is sampled; BR=0 on the same edge.
REQ-034 REQ_IN=11 in IDLE -> GNT=01 first; on REQ0 drop -> RELEASE, 4 gap cycles, then GNT=10.
REQ-035 BG_IN held 0 with REQ_IN=10 -> TIMEOUT pulses at cycle 1024 of REQUEST; BR=0 the next cycle; no GNT.
REQ-036 BG_IN=1 with AS_IN=1 for 5 cycles -> BGACK stays 0 throughout; BGACK=1 on the edge following the first AS_IN=0 sample.
REQ-037 REQ_IN=01 held for 300 cycles -> PREEMPT pulses after 256 OWN cycles; GNT=00 during RELEASE; requester 0 re-granted after the gap if no other request.
REQ-038 RESET_n_IN pulsed low mid-OWN -> BGACK, GNT and BR all 0 without waiting for a clock edge; state IDLE.
